aes_stream_bridge: RTL
======================

# aes_stream_bridge

- Host-side endpoint of the AES FIFO wrapper.
- Transmit path: accepts whole 128-bit plaintext/ciphertext blocks on a valid/ready port, serialises each into four 32-bit writes to the wrapper's input FIFO, and respects its almost-full flag.
- Receive path: drains the wrapper's output FIFO, reassembles four words into a 128-bit block and presents it on a valid/ready port.
- Also generates the wrapper's soft reset (flush) and keeps per-direction block counters for the register map.

## Interface

Parameters:
- CNT_W, 16, width of the block counters.

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  single-cycle request to abort and clear both paths.
- o_rst_control  out  1  soft reset to the AES FIFO wrapper.
- i_tx_valid  in  1  host block valid.
- i_tx_block  in  128  host block; [127:96] is word 0.
- o_tx_ready  out  1  bridge can accept a block.
- o_write_fifoIn  out  1  input-FIFO write request.
- o_data_fifoIn  out  32  input-FIFO write data.
- i_full_fifoIn  in  1  input-FIFO almost-full.
- o_read_fifoOut  out  1  output-FIFO read request.
- i_empty_fifoOut  in  1  output-FIFO empty.
- i_q_fifoOut  in  32  output-FIFO data, valid the cycle after the read request.
- o_rx_valid  out  1  reassembled block valid.
- o_rx_block  out  128  reassembled block; word 0 in [127:96].
- i_rx_ready  in  1  host accepts the block.
- o_tx_count  out  CNT_W  blocks fully written to the input FIFO.
- o_rx_count  out  CNT_W  blocks handed to the host.
- o_busy  out  1  TX not idle, or RX holding 1–4 words.

## Operation

**TX FSM (TX_IDLE, TX_SEND)**
- o_tx_ready = (state==TX_IDLE) & !i_flush.
- Block is accepted when i_tx_valid & o_tx_ready. On acceptance: capture i_tx_block into the shift register, clear the word index, go to TX_SEND.
- In TX_SEND:
  - o_write_fifoIn = !i_full_fifoIn (combinational).
  - o_data_fifoIn = shift[127:96].
  - Each write shifts left 32 bits and increments the index.
  - The write with index 3 increments o_tx_count and returns to TX_IDLE.
- While i_full_fifoIn is high: no write; word and index hold.

**RX FSM (RX_FILL, RX_HOLD)**
- In RX_FILL, o_read_fifoOut = !i_empty_fifoOut & (issued < 4).
- issued increments on each read.
- A registered read flag captures i_q_fifoOut one cycle later into the next word slot, packed MSW first. captured increments on each capture.
- When captured reaches 4: go to RX_HOLD and assert o_rx_valid.
- In RX_HOLD: no reads; o_rx_block is stable.
- On i_rx_ready: increment o_rx_count, clear issued and captured, return to RX_FILL.

**Flush**
- i_flush high registers o_rst_control high for exactly the next cycle.
- Same edge: both FSMs go to idle (TX_IDLE, RX_FILL), indices cleared, o_rx_valid cleared, partial data discarded, both counters cleared.
- The data regs (shift register, o_rx_block) need not be cleared.
- Flush has priority over every other event in the same cycle:
  - a TX offer in the flush cycle is not accepted;
  - a read in flight is discarded.

**Counters**
- Counters wrap modulo 2^CNT_W.

## Timing

- Reset values:
  - o_tx_ready = 1;
  - o_write_fifoIn, o_read_fifoOut, o_rx_valid, o_rst_control, o_busy = 0;
  - o_tx_count, o_rx_count, o_data_fifoIn, o_rx_block = 0.
- TX latency:
  - accept at edge N; words written at edges N+1..N+4 with no backpressure; TX_IDLE after N+4.
  - Sustained throughput: 1 block per 5 cycles.
- RX latency:
  - first read at cycle M (output FIFO non-empty); o_rx_valid high at M+5 with 4 words available back-to-back.
  - i_empty_fifoOut is updated on the consuming edge, so the bridge never over-reads.
- i_full_fifoIn and i_empty_fifoOut are sampled combinationally in the same cycle as the request they gate.
- Reset asserted mid-block: immediate return to the reset values; no partial FIFO write completes after reset.
- o_busy is registered, valid one cycle after the state change.

## Test plan

- **Single block, no backpressure:** send 0x00112233_44556677_8899AABB_CCDDEEFF → FIFO writes 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive cycles; o_tx_count = 1; o_tx_ready low exactly 4 cycles.
- **Backpressure:** i_full_fifoIn high for 3 cycles after word 1 → word 2 held on o_data_fifoIn, no write pulses; write resumes when full drops; total of exactly 4 writes.
- **RX reassembly with host stall:** preload 8 words 1..8, i_rx_ready low 10 cycles → o_rx_block = 0x00000001_00000002_00000003_00000004 stable; no reads during hold; after ready, second block = words 5..8; o_rx_count = 2.
- **Sparse RX:** empty toggles so words arrive 1 per 3 cycles → same block content; o_rx_valid only after the 4th capture.
- **Flush mid-operation:** flush after 2 TX words and 3 RX words → o_rst_control exactly 1 cycle; counters 0; o_rx_valid 0; next TX block writes all 4 words from word 0.
- **Counter wrap:** with CNT_W = 4, pass 17 blocks each way → both counters read 1.

Source files
------------

// File: rtl/aes_stream_bridge.sv
// Host-side bridge to the AES FIFO wrapper: 128-bit blocks <-> four 32-bit FIFO words, flush and block counters.
// TX: accept -> 4 writes (N+1..N+4), stalls on almost-full; RX: rx_valid 5 cycles after first read, holds until rx_ready.
module aes_stream_bridge #(
    parameter int CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    output logic               o_rst_control,
    input  logic               i_tx_valid,
    input  logic [127:0]       i_tx_block,
    output logic               o_tx_ready,
    output logic               o_write_fifoIn,
    output logic [31:0]        o_data_fifoIn,
    input  logic               i_full_fifoIn,
    output logic               o_read_fifoOut,
    input  logic               i_empty_fifoOut,
    input  logic [31:0]        i_q_fifoOut,
    output logic               o_rx_valid,
    output logic [127:0]       o_rx_block,
    input  logic               i_rx_ready,
    output logic [CNT_W-1:0]   o_tx_count,
    output logic [CNT_W-1:0]   o_rx_count,
    output logic               o_busy
);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic {RX_FILL, RX_HOLD} rx_state_t;

    tx_state_t    tx_state, tx_state_nxt;
    logic [127:0] tx_shift;
    logic [1:0]   tx_idx;
    logic         tx_accept;
    logic         tx_write;

    rx_state_t    rx_state, rx_state_nxt;
    logic [2:0]   rx_issued;
    logic [2:0]   rx_captured;
    logic         rd_pend;
    logic         rx_read;
    logic         rx_take;

    // Flush masks every handshake in its own cycle so nothing leaks past the soft reset.
    always_comb begin
        tx_state_nxt = tx_state;
        o_tx_ready   = (tx_state == TX_IDLE) && !i_flush;
        tx_accept    = i_tx_valid && o_tx_ready;
        tx_write     = (tx_state == TX_SEND) && !i_full_fifoIn && !i_flush;
        if (i_flush) begin
            tx_state_nxt = TX_IDLE;
        end else begin
            case (tx_state)
                TX_IDLE: if (tx_accept) tx_state_nxt = TX_SEND;
                TX_SEND: if (tx_write && tx_idx == 2'd3) tx_state_nxt = TX_IDLE;
                default: tx_state_nxt = TX_IDLE;
            endcase
        end
    end

    assign o_write_fifoIn = tx_write;
    assign o_data_fifoIn  = tx_shift[127:96];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state   <= TX_IDLE;
            tx_shift   <= '0;
            tx_idx     <= '0;
            o_tx_count <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            if (i_flush) begin
                tx_idx     <= '0;
                o_tx_count <= '0;
            end else if (tx_accept) begin
                tx_shift <= i_tx_block;
                tx_idx   <= '0;
            end else if (tx_write) begin
                tx_shift <= {tx_shift[95:0], 32'h0};
                tx_idx   <= tx_idx + 2'd1;
                if (tx_idx == 2'd3) o_tx_count <= o_tx_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rx_state_nxt   = rx_state;
        rx_read        = (rx_state == RX_FILL) && !i_empty_fifoOut && (rx_issued < 3'd4) && !i_flush;
        rx_take        = (rx_state == RX_HOLD) && i_rx_ready && !i_flush;
        if (i_flush) begin
            rx_state_nxt = RX_FILL;
        end else begin
            case (rx_state)
                RX_FILL: if (rd_pend && rx_captured == 3'd3) rx_state_nxt = RX_HOLD;
                RX_HOLD: if (rx_take) rx_state_nxt = RX_FILL;
                default: rx_state_nxt = RX_FILL;
            endcase
        end
    end

    assign o_read_fifoOut = rx_read;
    assign o_rx_valid     = (rx_state == RX_HOLD);

    // FIFO data lags the read by one cycle; rd_pend marks the cycle it is on the bus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_state    <= RX_FILL;
            rx_issued   <= '0;
            rx_captured <= '0;
            rd_pend     <= 1'b0;
            o_rx_block  <= '0;
            o_rx_count  <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            if (i_flush) begin
                rx_issued   <= '0;
                rx_captured <= '0;
                rd_pend     <= 1'b0;
                o_rx_count  <= '0;
            end else begin
                rd_pend <= rx_read;
                if (rx_read) rx_issued <= rx_issued + 3'd1;
                if (rd_pend) begin
                    o_rx_block  <= {o_rx_block[95:0], i_q_fifoOut};
                    rx_captured <= rx_captured + 3'd1;
                end
                if (rx_take) begin
                    rx_issued   <= '0;
                    rx_captured <= '0;
                    o_rx_count  <= o_rx_count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rst_control <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_rst_control <= i_flush;
            o_busy        <= (tx_state != TX_IDLE) || (rx_captured != 3'd0);
        end
    end

endmodule
